// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU MEM stage and a burst DMA engine.
// Optional build macro DMEM_ARB_STATS_EN adds saturating stall/beat counters on stat_*.
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_BURST    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [3:0]        dma_len,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_beat,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_done,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       stat_stall,
  output logic [15:0]       stat_beats
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BURST   = 2'd1,
    SUSPEND = 2'd2
  } state_t;

  state_t            r_state;
  logic [3:0]        r_idx;
  logic [3:0]        r_last;
  logic [ADDR_W-1:0] r_base;
  logic              r_we;
  logic [SW-1:0]     r_starve;
  logic              r_rvalid;
  logic              r_done;

  logic              w_cpu_req;
  logic [3:0]        w_len;
  logic [SW-1:0]     w_starve_inc;
  logic              w_last;
  logic              w_starved;
  logic [ADDR_W-1:0] w_beat_addr;

  assign w_cpu_req    = cpu_rd | cpu_wr;
  assign w_starve_inc = r_starve + 1'b1;
  assign w_last       = (r_idx == r_last);
  assign w_starved    = w_cpu_req && (w_starve_inc == SW'(STARVE_LIMIT));
  assign w_beat_addr  = r_base + ADDR_W'({r_idx, 2'b00});

  // A zero length still moves one word; oversized requests are cut to MAX_BURST.
  always_comb begin
    w_len = dma_len;
    if (dma_len == 4'd0) begin
      w_len = 4'd1;
    end else if (int'(dma_len) > MAX_BURST) begin
      w_len = 4'(MAX_BURST);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_last   <= '0;
      r_base   <= '0;
      r_we     <= 1'b0;
      r_starve <= '0;
      r_rvalid <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_rvalid <= (r_state == BURST) & ~r_we;
      r_done   <= 1'b0;
      case (r_state)
        IDLE: begin
          r_starve <= '0;
          if (dma_req && !w_cpu_req) begin
            r_state <= BURST;
            r_base  <= dma_addr;
            r_last  <= w_len - 4'd1;
            r_we    <= dma_we;
            r_idx   <= '0;
          end
        end
        BURST: begin
          r_starve <= w_cpu_req ? w_starve_inc : '0;
          if (w_last) begin
            r_state  <= IDLE;
            r_done   <= 1'b1;
            r_idx    <= '0;
            r_starve <= '0;
          end else begin
            r_idx <= r_idx + 4'd1;
            if (w_starved) begin
              r_state  <= SUSPEND;
              r_starve <= '0;
            end
          end
        end
        SUSPEND: begin
          r_starve <= '0;
          if (!w_cpu_req) begin
            r_state <= BURST;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Port steering is combinational so a CPU access reaches memory in its own cycle.
  // NOTE: every output gets a default first so no path through this block infers a latch.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_stall = 1'b0;
    dma_gnt   = 1'b0;
    dma_beat  = 1'b0;
    if (reset) begin
      if (r_state == BURST) begin
        mem_rd    = ~r_we;
        mem_wr    = r_we;
        mem_addr  = w_beat_addr;
        mem_wdata = dma_wdata;
        dma_beat  = 1'b1;
        cpu_stall = w_cpu_req;
      end else begin
        mem_rd    = cpu_rd & ~cpu_wr;
        mem_wr    = cpu_wr;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        dma_gnt   = (r_state == IDLE) & dma_req & ~w_cpu_req;
      end
    end
  end

  assign dma_rvalid = r_rvalid;
  assign dma_done   = r_done;
  // Read data is only presented while valid, keeping the port quiet otherwise.
  assign dma_rdata  = r_rvalid ? mem_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] r_stat_stall;
  logic [15:0] r_stat_beats;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_stall <= '0;
      r_stat_beats <= '0;
    end else begin
      if (cpu_stall && (r_stat_stall != 16'hFFFF)) begin
        r_stat_stall <= r_stat_stall + 16'd1;
      end
      if (dma_beat && (r_stat_beats != 16'hFFFF)) begin
        r_stat_beats <= r_stat_beats + 16'd1;
      end
    end
  end

  assign stat_stall = r_stat_stall;
  assign stat_beats = r_stat_beats;
`else
  assign stat_stall = '0;
  assign stat_beats = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: expected beats and read data are queued when a burst
// is requested and popped as the DUT issues them; control outputs are checked inline.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_stall;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr;
  logic [3:0]  dma_len;
  logic [31:0] dma_wdata;
  logic        dma_gnt, dma_beat, dma_rvalid, dma_done;
  logic [31:0] dma_rdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [15:0] stat_stall, stat_beats;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_BURST(8), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_beat(dma_beat),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_done(dma_done),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stat_stall(stat_stall), .stat_beats(stat_beats)
  );

  function automatic logic [31:0] mem_init(input logic [7:0] idx);
    return {24'hA50000, idx};
  endfunction

  function automatic logic [31:0] wpat(input int n);
    return 32'hD000_0000 + 32'(n);
  endfunction

  // Synchronous read-only memory: a fixed pattern, data valid the cycle after mem_rd.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem_init(mem_addr[9:2]);
  end

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  beat_t       exp_beats[$];
  logic [31:0] exp_rdata[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          beat_cnt = 0;
  logic        beat_seen = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {25'd0, mem_rd, mem_wr, mem_addr, mem_wdata, cpu_stall, dma_gnt,
            dma_beat, dma_rvalid, dma_done, dma_rdata};
  endfunction

  task automatic push_burst(input logic we, input logic [31:0] base, input int n);
    beat_t e;
    for (int k = 0; k < n; k++) begin
      e.we    = we;
      e.addr  = base + 32'(4 * k);
      e.wdata = wpat(beat_cnt + k);
      exp_beats.push_back(e);
      if (!we) exp_rdata.push_back(mem_init(e.addr[9:2]));
    end
  endtask

  // Mid-cycle sample: scoreboard any beat or returned read word.
  task automatic sample();
    beat_t       e;
    logic [31:0] r;
    @(negedge clk);
    beat_seen = dma_beat;
    if (dma_beat) begin
      check("beat_expected", 128'(exp_beats.size() != 0), 128'(1));
      if (exp_beats.size() != 0) begin
        e = exp_beats.pop_front();
        check("beat_addr", 128'(mem_addr), 128'(e.addr));
        check("beat_dir", 128'({mem_rd, mem_wr}), 128'(e.we ? 2'b01 : 2'b10));
        if (e.we) check("beat_wdata", 128'(mem_wdata), 128'(e.wdata));
      end
    end
    if (dma_rvalid) begin
      check("rdata_expected", 128'(exp_rdata.size() != 0), 128'(1));
      if (exp_rdata.size() != 0) begin
        r = exp_rdata.pop_front();
        check("dma_rdata", 128'(dma_rdata), 128'(r));
      end
    end
  endtask

  // Step past the edge; the DMA model advances its write data after each beat.
  task automatic advance();
    @(posedge clk);
    #1;
    if (beat_seen) begin
      beat_cnt++;
      dma_wdata = wpat(beat_cnt);
    end
    beat_seen = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_len = '0;
    dma_wdata = wpat(0);

    // Reset and release
    sample();
    check("reset_outs", all_outs(), 128'(0));
    advance();
    reset = 1'b1;
    sample();
    check("post_reset_outs", all_outs(), 128'(0));
    advance();

    // CPU read passes straight through
    cpu_rd = 1'b1; cpu_addr = 32'h40;
    sample();
    check("cpu_rd_strobe", 128'({mem_rd, mem_wr}), 128'(2'b10));
    check("cpu_rd_addr", 128'(mem_addr), 128'(32'h40));
    check("cpu_rd_stall", 128'(cpu_stall), 128'(0));
    advance();

    // Read and write together is a write
    cpu_wr = 1'b1; cpu_addr = 32'h44; cpu_wdata = 32'h0000_CAFE;
    sample();
    check("illegal_as_write", 128'({mem_rd, mem_wr}), 128'(2'b01));
    check("illegal_wdata", 128'(mem_wdata), 128'(32'h0000_CAFE));
    advance();
    cpu_rd = 1'b0; cpu_wr = 1'b0;

    // Write burst, len 4 at 0x100
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h100; dma_len = 4'd4;
    push_burst(1'b1, 32'h100, 4);
    sample();
    check("wr4_gnt", 128'(dma_gnt), 128'(1));
    check("wr4_gnt_no_beat", 128'(dma_beat), 128'(0));
    advance();
    dma_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sample();
      check("wr4_beat", 128'(dma_beat), 128'(1));
      check("wr4_no_early_done", 128'(dma_done), 128'(0));
      advance();
    end
    sample();
    check("wr4_done", 128'(dma_done), 128'(1));
    check("wr4_beats_end", 128'(dma_beat), 128'(0));
    advance();
    sample();
    check("wr4_done_pulse", 128'(dma_done), 128'(0));
    advance();

    // Read burst, len 0 is one beat
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h200; dma_len = 4'd0;
    push_burst(1'b0, 32'h200, 1);
    sample();
    check("rd0_gnt", 128'(dma_gnt), 128'(1));
    advance();
    dma_req = 1'b0;
    sample();
    check("rd0_beat", 128'(dma_beat), 128'(1));
    check("rd0_rvalid_early", 128'(dma_rvalid), 128'(0));
    advance();
    sample();
    check("rd0_rvalid", 128'(dma_rvalid), 128'(1));
    check("rd0_single_beat", 128'(dma_beat), 128'(0));
    check("rd0_done", 128'(dma_done), 128'(1));
    advance();
    sample();
    check("rd0_rvalid_pulse", 128'(dma_rvalid), 128'(0));
    advance();

    // Starvation: CPU read held 6 cycles during a len 8 burst
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h100; dma_len = 4'd8;
    push_burst(1'b1, 32'h100, 8);
    sample();
    check("st_gnt", 128'(dma_gnt), 128'(1));
    advance();
    dma_req = 1'b0; cpu_rd = 1'b1; cpu_addr = 32'h80;
    for (int k = 0; k < 4; k++) begin
      sample();
      check("st_stall", 128'(cpu_stall), 128'(1));
      check("st_beat", 128'(dma_beat), 128'(1));
      advance();
    end
    for (int k = 0; k < 2; k++) begin
      sample();
      check("st_susp_stall", 128'(cpu_stall), 128'(0));
      check("st_susp_beat", 128'(dma_beat), 128'(0));
      check("st_susp_cpu", 128'({mem_rd, mem_wr, mem_addr}), 128'({2'b10, 32'h80}));
      advance();
    end
    cpu_rd = 1'b0;
    sample();
    check("st_susp_idle_beat", 128'(dma_beat), 128'(0));
    check("st_susp_idle_strobe", 128'({mem_rd, mem_wr}), 128'(2'b00));
    advance();
    sample();
    check("st_resume_addr", 128'(mem_addr), 128'(32'h110));
    check("st_resume_beat", 128'(dma_beat), 128'(1));
    advance();
    for (int k = 0; k < 3; k++) begin
      sample();
      check("st_tail_beat", 128'(dma_beat), 128'(1));
      check("st_tail_stall", 128'(cpu_stall), 128'(0));
      advance();
    end
    sample();
    check("st_done", 128'(dma_done), 128'(1));
    advance();

    // CPU write and DMA request collide: CPU first
    cpu_wr = 1'b1; cpu_addr = 32'h300; cpu_wdata = 32'h1234_5678;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h180; dma_len = 4'd2;
    sample();
    check("col_cpu_wr", 128'({mem_rd, mem_wr, mem_addr, mem_wdata}),
          128'({2'b01, 32'h300, 32'h1234_5678}));
    check("col_no_gnt", 128'(dma_gnt), 128'(0));
    check("col_no_stall", 128'(cpu_stall), 128'(0));
    advance();
    cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    push_burst(1'b1, 32'h180, 2);
    sample();
    check("col_gnt", 128'(dma_gnt), 128'(1));
    advance();
    dma_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sample();
      check("col_beat", 128'(dma_beat), 128'(1));
      advance();
    end
    sample();
    check("col_done", 128'(dma_done), 128'(1));
    advance();

    // Length clamp to MAX_BURST with address wrap
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'hFFFF_FFF0; dma_len = 4'd12;
    push_burst(1'b1, 32'hFFFF_FFF0, 8);
    sample();
    check("clamp_gnt", 128'(dma_gnt), 128'(1));
    advance();
    dma_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      sample();
      check("clamp_beat", 128'(dma_beat), 128'(1));
      advance();
    end
    sample();
    check("clamp_done", 128'(dma_done), 128'(1));
    check("clamp_stop", 128'(dma_beat), 128'(0));
    advance();

    // Reset mid-burst at beat 2
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h140; dma_len = 4'd4;
    push_burst(1'b1, 32'h140, 2);
    sample();
    check("rst_gnt", 128'(dma_gnt), 128'(1));
    advance();
    dma_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sample();
      check("rst_pre_beat", 128'(dma_beat), 128'(1));
      advance();
    end
    reset = 1'b0;
    #1;
    check("rst_async_outs", all_outs(), 128'(0));
    sample();
    check("rst_held_beat", 128'(dma_beat), 128'(0));
    advance();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sample();
      check("rst_no_done", 128'(dma_done), 128'(0));
      check("rst_no_beat", 128'(dma_beat), 128'(0));
      advance();
    end
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h140; dma_len = 4'd1;
    push_burst(1'b1, 32'h140, 1);
    sample();
    check("rst_regnt", 128'(dma_gnt), 128'(1));
    advance();
    dma_req = 1'b0;
    sample();
    check("rst_restart_beat", 128'(dma_beat), 128'(1));
    advance();
    sample();
    check("rst_restart_done", 128'(dma_done), 128'(1));
    advance();

    // Statistics since the last reset: one beat, no stalls
`ifdef DMEM_ARB_STATS_EN
    check("stat_stall", 128'(stat_stall), 128'(0));
    check("stat_beats", 128'(stat_beats), 128'(1));
`else
    check("stat_tied", 128'({stat_stall, stat_beats}), 128'(0));
`endif

    check("beats_drained", 128'(exp_beats.size()), 128'(0));
    check("rdata_drained", 128'(exp_rdata.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
